sr_pulse_conditioner: RTL



---
 rtl/sr_latch_pkg.sv | 22 ++
 rtl/sr_debounce.sv | 75 +++++++
 rtl/sr_pulse_conditioner.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sr_latch_pkg.sv
// Shared definitions for the SR latch front-end: conditioner FSM states,
// default timing constants and the latch pin map.
package sr_latch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SET_P = 2'd1,
      RST_P = 2'd2,
      GUARD = 2'd3
   } pc_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_PULSE_WIDTH     = 4;
   localparam int DEF_CNT_W           = 5;

   // Latch pin map: S/R on ui_in, Q/Qn on uo_out
   localparam int LATCH_S_BIT  = 0;
   localparam int LATCH_R_BIT  = 1;
   localparam int LATCH_Q_BIT  = 0;
   localparam int LATCH_QN_BIT = 1;

endpackage

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter and a one-cycle
// request on each accepted rising level change.
module sr_debounce
   import sr_latch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic req_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

   logic             meta_q;
   logic             sync_q;
   logic             stable_q,  stable_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             armed_q,   armed_d;
   logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;
   logic             req_q,     req_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      req_d    = 1'b0;
      if (sync_q != stable_q) begin
         if (cnt_q >= CNT_LAST) begin
            stable_d = sync_q;
            req_d    = sync_q & armed_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // A button still held through reset must not fire: requests are only
   // armed once the synchronized input has been seen low for a full debounce.
   always_comb begin
      armed_d   = armed_q;
      arm_cnt_d = '0;
      if (!armed_q && !sync_q) begin
         if (arm_cnt_q >= CNT_LAST) begin
            armed_d = 1'b1;
         end else begin
            arm_cnt_d = arm_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q    <= 1'b0;
         sync_q    <= 1'b0;
         stable_q  <= 1'b0;
         cnt_q     <= '0;
         armed_q   <= 1'b0;
         arm_cnt_q <= '0;
         req_q     <= 1'b0;
      end else begin
         meta_q    <= btn_i;
         sync_q    <= meta_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         arm_cnt_q <= arm_cnt_d;
         req_q     <= req_d;
      end
   end

   assign req_o = req_q;

endmodule

// File: rtl/sr_pulse_conditioner.sv
// Turns debounced set/reset button presses into fixed-width, mutually
// exclusive pulses for the NOR SR latch, never presenting S=R=1.
module sr_pulse_conditioner
   import sr_latch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int PULSE_WIDTH     = DEF_PULSE_WIDTH,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic btn_set,
   input  logic btn_reset,
   output logic set_pulse,
   output logic reset_pulse,
   output logic conflict,
   output logic busy
);

   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);

   logic             req_set;
   logic             req_rst;
   logic             both_req;
   pc_state_e        state_q;
   logic             set_pulse_q;
   logic             reset_pulse_q;
   logic [CNT_W-1:0] pcnt_q;
   logic             pend_set_q,  pend_set_d;
   logic             pend_rst_q,  pend_rst_d;
   logic             first_set_q, first_set_d;

   sr_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_dbnc_set (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (btn_set),
      .req_o (req_set)
   );

   sr_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_dbnc_rst (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (btn_reset),
      .req_o (req_rst)
   );

   // first_set tracks arrival order; it only matters while both are pending
   always_comb begin
      both_req   = req_set & req_rst;
      pend_set_d = pend_set_q | req_set;
      pend_rst_d = pend_rst_q | req_rst;
      if (both_req) begin
         pend_set_d = 1'b0;
         pend_rst_d = 1'b0;
      end
      first_set_d = (pend_set_d & pend_rst_d) ? first_set_q : pend_set_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         set_pulse_q   <= 1'b0;
         reset_pulse_q <= 1'b0;
         pcnt_q        <= '0;
         pend_set_q    <= 1'b0;
         pend_rst_q    <= 1'b0;
         first_set_q   <= 1'b0;
      end else if (!ena) begin
         state_q       <= IDLE;
         set_pulse_q   <= 1'b0;
         reset_pulse_q <= 1'b0;
         pcnt_q        <= '0;
         pend_set_q    <= 1'b0;
         pend_rst_q    <= 1'b0;
         first_set_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               pcnt_q      <= '0;
               pend_set_q  <= 1'b0;
               pend_rst_q  <= 1'b0;
               first_set_q <= 1'b0;
               if (req_set && !req_rst) begin
                  state_q     <= SET_P;
                  set_pulse_q <= 1'b1;
               end else if (req_rst && !req_set) begin
                  state_q       <= RST_P;
                  reset_pulse_q <= 1'b1;
               end
            end
            SET_P, RST_P: begin
               pend_set_q  <= pend_set_d;
               pend_rst_q  <= pend_rst_d;
               first_set_q <= first_set_d;
               if (pcnt_q >= PULSE_LAST) begin
                  state_q       <= GUARD;
                  set_pulse_q   <= 1'b0;
                  reset_pulse_q <= 1'b0;
                  pcnt_q        <= '0;
               end else begin
                  pcnt_q <= pcnt_q + CNT_W'(1);
               end
            end
            GUARD: begin
               pcnt_q <= '0;
               if (pend_set_d && (!pend_rst_d || first_set_d)) begin
                  state_q     <= SET_P;
                  set_pulse_q <= 1'b1;
                  pend_set_q  <= 1'b0;
                  pend_rst_q  <= pend_rst_d;
                  first_set_q <= 1'b0;
               end else if (pend_rst_d) begin
                  state_q       <= RST_P;
                  reset_pulse_q <= 1'b1;
                  pend_rst_q    <= 1'b0;
                  pend_set_q    <= pend_set_d;
                  first_set_q   <= pend_set_d;
               end else begin
                  state_q     <= IDLE;
                  pend_set_q  <= 1'b0;
                  pend_rst_q  <= 1'b0;
                  first_set_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign set_pulse   = set_pulse_q;
   assign reset_pulse = reset_pulse_q;
   assign conflict    = ena & both_req;
   assign busy        = (state_q != IDLE);

endmodule
